multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/ctrl_decode.sv | 32 +++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ctrl_pkg                                               |
// | Description : Shared encodings for the multicycle controller: FSM    |
// |               state, instruction class, major opcodes, ALUop codes.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_R  = 3'd0,
      CLS_I  = 3'd1,
      CLS_LW = 3'd2,
      CLS_SW = 3'd3,
      CLS_BR = 3'd4
   } instr_class_t;

   localparam logic [6:0] C_OP_R  = 7'b0110011;
   localparam logic [6:0] C_OP_I  = 7'b0010011;
   localparam logic [6:0] C_OP_LW = 7'b0000011;
   localparam logic [6:0] C_OP_SW = 7'b0100011;
   localparam logic [6:0] C_OP_BR = 7'b1100011;

   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ctrl_decode                                            |
// | Description : Combinational opcode-to-class decoder.                 |
// | Ports       : opcode [6:0] in  - instruction bits [6:0]              |
// |               cls          out - decoded instruction class           |
// |               legal        out - 1 when opcode is a supported class  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0]   opcode,
   output instr_class_t cls,
   output logic         legal
);

   always_comb begin
      cls   = CLS_R;
      legal = 1'b1;
      case (opcode)
         C_OP_R:  cls = CLS_R;
         C_OP_I:  cls = CLS_I;
         C_OP_LW: cls = CLS_LW;
         C_OP_SW: cls = CLS_SW;
         C_OP_BR: cls = CLS_BR;
         default: legal = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : multicycle_ctrl                                        |
// | Description : Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/  |
// |               TRAP) with instruction-class latch and retire counter. |
// | Ports       : clk, rst_n (async, active low)                         |
// |               opcode, funct3, zero        - instruction / ALU inputs |
// |               imem_req/imem_ready         - fetch handshake          |
// |               dmem_req/dmem_we/dmem_ready - data-memory handshake    |
// |               IRWrite, PCWrite, PCsel, ALUsrc, ALUop, RegWrite,      |
// |               MemtoReg                    - datapath controls        |
// |               illegal, retire_cnt         - status                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        zero,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCsel,
   output logic        ALUsrc,
   output logic [1:0]  ALUop,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        illegal,
   output logic [31:0] retire_cnt
);

   state_t       r_state;
   instr_class_t r_cls;
   logic         r_active;
   logic [31:0]  r_retire_cnt;

   instr_class_t w_dec_cls;
   logic         w_dec_legal;
   logic         w_unused_funct3;

   // Only funct3[0] (BEQ/BNE select) matters to the controller.
   assign w_unused_funct3 = ^funct3[2:1];

   ctrl_decode u_decode (
      .opcode (opcode),
      .cls    (w_dec_cls),
      .legal  (w_dec_legal)
   );

   // r_active stays low from reset until the first rising edge after
   // release; this keeps every output at 0 while rst_n is low and makes
   // the first post-reset edge the one that starts FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_FETCH;
         r_cls        <= CLS_R;
         r_active     <= 1'b0;
         r_retire_cnt <= 32'd0;
      end else begin
         r_active <= 1'b1;
         if (PCWrite) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
         end
         if (r_active) begin
            case (r_state)
               ST_FETCH: begin
                  if (imem_ready) begin
                     r_state <= ST_DECODE;
                  end
               end
               ST_DECODE: begin
                  if (w_dec_legal) begin
                     r_cls   <= w_dec_cls;
                     r_state <= ST_EXEC;
                  end else begin
                     r_state <= ST_TRAP;
                  end
               end
               ST_EXEC: begin
                  case (r_cls)
                     CLS_R, CLS_I:   r_state <= ST_WB;
                     CLS_LW, CLS_SW: r_state <= ST_MEM;
                     default:        r_state <= ST_FETCH;
                  endcase
               end
               ST_MEM: begin
                  if (dmem_ready) begin
                     r_state <= (r_cls == CLS_SW) ? ST_FETCH : ST_WB;
                  end
               end
               ST_WB:   r_state <= ST_FETCH;
               ST_TRAP: r_state <= ST_TRAP;
               default: r_state <= ST_FETCH;
            endcase
         end
      end
   end

   // Outputs decode from the state register; the ready-qualified strobes
   // (IRWrite, SW PCWrite) and the branch decision depend on inputs
   // sampled in the same cycle.
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCsel    = 1'b0;
      ALUsrc   = 1'b0;
      ALUop    = C_ALUOP_ADD;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      if (r_active) begin
         case (r_state)
            ST_FETCH: begin
               imem_req = 1'b1;
               IRWrite  = imem_ready;
            end
            ST_EXEC: begin
               case (r_cls)
                  CLS_R: begin
                     ALUop = C_ALUOP_FUNCT;
                  end
                  CLS_I: begin
                     ALUsrc = 1'b1;
                     ALUop  = C_ALUOP_FUNCT;
                  end
                  CLS_LW, CLS_SW: begin
                     ALUsrc = 1'b1;
                     ALUop  = C_ALUOP_ADD;
                  end
                  CLS_BR: begin
                     ALUop   = C_ALUOP_SUB;
                     PCWrite = 1'b1;
                     // BEQ takes on zero=1, BNE on zero=0.
                     PCsel   = zero ^ funct3[0];
                  end
                  default: begin
                     ALUop = C_ALUOP_ADD;
                  end
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (r_cls == CLS_SW);
               ALUsrc   = 1'b1;
               ALUop    = C_ALUOP_ADD;
               PCWrite  = dmem_ready && (r_cls == CLS_SW);
            end
            ST_WB: begin
               RegWrite = 1'b1;
               MemtoReg = (r_cls == CLS_LW);
               PCWrite  = 1'b1;
            end
            default: begin
               imem_req = 1'b0;
            end
         endcase
      end
   end

   assign illegal    = (r_state == ST_TRAP);
   assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire
